// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle RV32I-subset control FSM
// Sequences shared ALU/memory per state, generates immediates, counts retired instructions.
module multicycle_sequencer #(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           aluop,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [31:0]          imm,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [INSTRET_W-1:0] instret
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
    S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t                 state_q;
  logic [WAIT_W-1:0]      wait_q;
  logic                   illegal_q;
  logic                   bus_error_q;
  logic [INSTRET_W-1:0]   instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       req_active;
  logic       timeout;
  logic       branch_ok;
  logic       taken;
  logic       retire;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign req_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout    = (MEM_TIMEOUT != 0) && req_active && (wait_q == WAIT_LIMIT);
  assign branch_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100);
  assign taken      = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero) ||
                      ((funct3 == 3'b100) && lt);
  // A timed-out request never retires, even if mem_ready shows up in that same cycle.
  assign retire     = !timeout && ((state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                      (state_q == S_JAL) || ((state_q == S_MEM_WR) && mem_ready) ||
                      ((state_q == S_BRANCH) && branch_ok));

  always_comb begin
    imm = 32'd0;
    case (opcode)
      OP_LOAD, OP_IMM: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:       imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_JAL:          imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:         imm = 32'd0;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_source = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    aluop     = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
      S_MEM_ADDR: begin alu_src_a = 2'b10; alu_src_b = 2'b10; end
      S_MEM_RD:   begin mem_read = 1'b1; iord = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; wb_sel = 2'b01; end
      S_MEM_WR:   begin mem_write = 1'b1; iord = 1'b1; end
      S_EXEC_R:   begin alu_src_a = 2'b10; aluop = 2'b10; end
      S_EXEC_I:   begin alu_src_a = 2'b10; alu_src_b = 2'b10; aluop = 2'b10; end
      S_ALU_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        aluop     = 2'b01;
        pc_source = 2'b01;
        pc_write  = taken;
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_source = 2'b01;
      end
      default: ;
    endcase
    if (rst || timeout) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      instret_q   <= '0;
    end else begin
      if (retire) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
      if (MEM_TIMEOUT != 0 && req_active && !mem_ready) wait_q <= wait_q + WAIT_W'(1);
      else                                              wait_q <= '0;
      if (timeout) begin
        state_q     <= S_TRAP;
        bus_error_q <= 1'b1;
        wait_q      <= '0;
      end else begin
        case (state_q)
          S_FETCH:  if (mem_ready) state_q <= S_DECODE;
          S_DECODE: begin
            case (opcode)
              OP_LOAD, OP_STORE: state_q <= S_MEM_ADDR;
              OP_REG:            state_q <= S_EXEC_R;
              OP_IMM:            state_q <= S_EXEC_I;
              OP_BRANCH:         state_q <= S_BRANCH;
              OP_JAL:            state_q <= S_JAL;
              default: begin
                state_q   <= S_TRAP;
                illegal_q <= 1'b1;
              end
            endcase
          end
          S_MEM_ADDR: state_q <= (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
          S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
          S_MEM_WB:   state_q <= S_FETCH;
          S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
          S_EXEC_R:   state_q <= S_ALU_WB;
          S_EXEC_I:   state_q <= S_ALU_WB;
          S_ALU_WB:   state_q <= S_FETCH;
          S_BRANCH: begin
            if (branch_ok) state_q <= S_FETCH;
            else begin
              state_q   <= S_TRAP;
              illegal_q <= 1'b1;
            end
          end
          S_JAL:      state_q <= S_FETCH;
          S_TRAP:     state_q <= S_TRAP;
          default:    state_q <= S_FETCH;
        endcase
      end
    end
  end

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
// Instruction-level reference model pushes per-cycle expectations; a negedge monitor compares.
module tb_multicycle_sequencer;
  localparam int IW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst, zero, lt, mem_ready;
  logic [31:0]   inst;
  logic          mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic [1:0]    pc_source, alu_src_a, alu_src_b, aluop, wb_sel;
  logic [31:0]   imm;
  logic [3:0]    state;
  logic          illegal, bus_error;
  logic [IW-1:0] instret;

  multicycle_sequencer #(.INSTRET_W(IW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .inst(inst), .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .reg_write(reg_write), .wb_sel(wb_sel),
    .imm(imm), .state(state), .illegal(illegal), .bus_error(bus_error), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    state;
    logic          mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]    pc_source, alu_src_a, alu_src_b, aluop;
    logic          reg_write;
    logic [1:0]    wb_sel;
    logic [31:0]   imm;
    logic          illegal, bus_error;
    logic [IW-1:0] instret;
  } obs_t;

  obs_t          sb[$];
  obs_t          mon_exp, mon_act;
  int            checks = 0;
  int            errors = 0;
  int            trap_len = 3;
  logic [IW-1:0] m_instret;
  logic          m_illegal, m_buserr;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_act = {state, mem_read, mem_write, iord, ir_write, pc_write, pc_source, alu_src_a,
                 alu_src_b, aluop, reg_write, wb_sel, imm, illegal, bus_error, instret};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL ctl t=%0t exp_state=%0d act=%h exp=%h", $time, mon_exp.state, mon_act, mon_exp);
      end
    end
  end

  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    logic signed [31:0] sx, t;
    sx = x;
    case (x[6:0])
      7'h03, 7'h13: begin t = sx >>> 20; return t; end
      7'h23: begin t = sx >>> 25; return (t << 5) | {27'd0, x[11:7]}; end
      7'h63: begin t = sx >>> 31; return (t << 12) | {20'd0, x[7], x[30:25], x[11:8], 1'b0}; end
      7'h6F: begin t = sx >>> 31; return (t << 20) | {12'd0, x[19:12], x[20], x[30:21], 1'b0}; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic obs_t base(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.state = st;
    e.imm = ref_imm(inst);
    e.illegal = m_illegal;
    e.bus_error = m_buserr;
    e.instret = m_instret;
    return e;
  endfunction

  function automatic obs_t quiet(input obs_t e);
    e.mem_read = 1'b0; e.mem_write = 1'b0; e.ir_write = 1'b0;
    e.pc_write = 1'b0; e.reg_write = 1'b0;
    return e;
  endfunction

  function automatic obs_t fetch_obs();
    obs_t e;
    e = base(4'd0);
    e.mem_read = 1'b1;
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    logic [6:0]  op;
    logic [2:0]  f3;
    int          r;
    x = $urandom;
    r = $urandom_range(0, 19);
    if (r <= 3)       op = 7'h03;
    else if (r <= 6)  op = 7'h23;
    else if (r <= 9)  op = 7'h33;
    else if (r <= 12) op = 7'h13;
    else if (r <= 15) op = 7'h63;
    else if (r <= 17) op = 7'h6F;
    else if (r == 18) begin
      do op = 7'($urandom); while (op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F});
    end else op = 7'h63;
    x[6:0] = op;
    if (op == 7'h63) begin
      if (r == 19) begin
        do f3 = 3'($urandom); while (f3 inside {3'd0, 3'd1, 3'd4});
      end else begin
        case ($urandom_range(0, 2))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          default: f3 = 3'd4;
        endcase
      end
      x[14:12] = f3;
    end
    return x;
  endfunction

  task automatic step(input obs_t e, input logic rdy);
    mem_ready = rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input obs_t e);
    step(e, 1'($urandom_range(0, 1)));
  endtask

  task automatic retire_one();
    m_instret = m_instret + 1'b1;
  endtask

  task automatic mem_wait(input obs_t w, input obs_t done, input int n, output bit to);
    to = 1'b0;
    if (n >= TO) begin
      for (int i = 0; i < TO; i++) step(w, 1'b0);
      step(quiet(w), 1'b0);
      m_buserr = 1'b1;
      to = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) step(w, 1'b0);
      step(done, 1'b1);
    end
  endtask

  task automatic do_reset(input obs_t cur);
    rst = 1'b1;
    idle_step(quiet(cur));
    m_instret = '0;
    m_illegal = 1'b0;
    m_buserr = 1'b0;
    idle_step(quiet(fetch_obs()));
    rst = 1'b0;
  endtask

  task automatic trap_then_reset();
    for (int i = 0; i < trap_len; i++) idle_step(base(4'd11));
    do_reset(base(4'd11));
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, input logic l, input int abort_after);
    obs_t e, d;
    bit   to;
    logic [2:0] f3;
    inst = ins; zero = z; lt = l;
    e = fetch_obs();
    d = e; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_wait(e, d, fw, to);
    if (to) begin trap_then_reset(); return; end
    e = base(4'd1); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
    idle_step(e);
    case (ins[6:0])
      7'h03, 7'h23: begin
        e = base(4'd2); e.alu_src_a = 2'b10; e.alu_src_b = 2'b10;
        idle_step(e);
        if (ins[6:0] == 7'h03) begin
          e = base(4'd3); e.mem_read = 1'b1; e.iord = 1'b1;
          if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) step(e, 1'b0);
            do_reset(e);
            return;
          end
          mem_wait(e, e, mw, to);
          if (to) begin trap_then_reset(); return; end
          e = base(4'd4); e.reg_write = 1'b1; e.wb_sel = 2'b01;
          idle_step(e);
          retire_one();
        end else begin
          e = base(4'd5); e.mem_write = 1'b1; e.iord = 1'b1;
          mem_wait(e, e, mw, to);
          if (to) begin trap_then_reset(); return; end
          retire_one();
        end
      end
      7'h33, 7'h13: begin
        e = base((ins[6:0] == 7'h33) ? 4'd6 : 4'd7);
        e.alu_src_a = 2'b10;
        e.alu_src_b = (ins[6:0] == 7'h33) ? 2'b00 : 2'b10;
        e.aluop = 2'b10;
        idle_step(e);
        e = base(4'd8); e.reg_write = 1'b1;
        idle_step(e);
        retire_one();
      end
      7'h63: begin
        f3 = ins[14:12];
        e = base(4'd9); e.alu_src_a = 2'b10; e.aluop = 2'b01; e.pc_source = 2'b01;
        if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4) begin
          e.pc_write = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : l;
          idle_step(e);
          retire_one();
        end else begin
          idle_step(e);
          m_illegal = 1'b1;
          trap_then_reset();
        end
      end
      7'h6F: begin
        e = base(4'd10); e.reg_write = 1'b1; e.wb_sel = 2'b10;
        e.pc_write = 1'b1; e.pc_source = 2'b01;
        idle_step(e);
        retire_one();
      end
      default: begin
        m_illegal = 1'b1;
        trap_then_reset();
      end
    endcase
  endtask

  initial begin
    int fw, mw, ab;
    rst = 1'b1; inst = 32'd0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
    m_instret = '0; m_illegal = 1'b0; m_buserr = 1'b0;
    @(posedge clk);
    #1;
    step(quiet(fetch_obs()), 1'b0);
    rst = 1'b0;

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, -1);
    run_instr(32'hFFC0A283, 1, 3, 1'b0, 1'b0, -1);
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, -1);
    run_instr(32'h00208463, 2, 0, 1'b0, 1'b0, -1);
    run_instr(32'h0020C463, 0, 0, 1'b0, 1'b1, -1);
    run_instr(32'hFE209EE3, 0, 0, 1'b0, 1'b0, -1);
    run_instr(32'hFE112E23, 0, 2, 1'b0, 1'b0, -1);
    run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, -1);
    run_instr(32'hFFC0A283, 0, 0, 1'b0, 1'b0, 2);
    trap_len = 20;
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, -1);
    trap_len = 3;
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, -1);
    run_instr(32'h002081B3, TO, 0, 1'b0, 1'b0, -1);
    run_instr(32'hFFC0A283, 0, TO, 1'b0, 1'b0, -1);

    repeat (400) begin
      fw = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, 3);
      mw = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, 3);
      ab = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(rand_inst(), fw, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
